// File: rtl/rtc_div_multi.sv
// Purpose : multi-channel programmable clock divider; each channel emits a 50% square wave of period 2*(H+1).
// Latency : clk_o/tick_o are registered; a new half-period is applied at the next wrap, disable or sync.
// Backpres: cfg_ready_o drops while the addressed channel still holds an unapplied value.
//
// Ports:
//   clk_i, rst_ni  - single clock, asynchronous active-low reset
//   en_i           - per-channel run enable; a disabled channel is held at cnt=0, clk_o=0
//   sync_i         - restarts every channel from phase 0
//   cfg_valid_i/cfg_ready_o, cfg_chan_i, cfg_half_i - half-period (minus one) write port
//   cfg_err_o      - one-cycle pulse after a write to a channel index >= NumChan
//   clk_o, tick_o  - divided clocks and their rising-edge pulses
module rtc_div_multi #(
  parameter int NumChan   = 2,
  parameter int CntWidth  = 16,
  parameter int ResetHalf = 24,
  localparam int ChanW    = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumChan-1:0]  en_i,
  input  logic                sync_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [ChanW-1:0]    cfg_chan_i,
  input  logic [CntWidth-1:0] cfg_half_i,
  output logic                cfg_err_o,
  output logic [NumChan-1:0]  clk_o,
  output logic [NumChan-1:0]  tick_o
);

  localparam logic [CntWidth-1:0] HalfRst  = CntWidth'(ResetHalf);
  localparam logic [ChanW:0]      NumChanL = (ChanW + 1)'(NumChan);

  logic [CntWidth-1:0] r_cnt    [NumChan];
  logic [CntWidth-1:0] r_half   [NumChan];
  logic [CntWidth-1:0] r_shadow [NumChan];
  logic [NumChan-1:0]  r_pend;
  logic [NumChan-1:0]  r_clk;
  logic [NumChan-1:0]  r_tick;
  logic                r_cfg_err;

  logic                    w_chan_ok;
  logic [(1<<ChanW)-1:0]   w_pend_ext;
  logic [NumChan-1:0]      w_hold;
  logic [NumChan-1:0]      w_wrap;
  logic [NumChan-1:0]      w_wr;
  logic [NumChan-1:0]      w_apply;

  // Pending flags padded to the full index range so out-of-range
  // channel numbers read as "not pending" and are always accepted.
  always_comb begin
    w_pend_ext = '0;
    for (int c = 0; c < NumChan; c++) begin
      w_pend_ext[c] = r_pend[c];
    end
  end

  assign w_chan_ok   = ({1'b0, cfg_chan_i} < NumChanL);
  assign cfg_ready_o = ~w_pend_ext[cfg_chan_i];

  // A write only lands when the channel has nothing pending, and a value is
  // only applied when something is pending, so the two never coincide: a
  // write accepted on a wrap/disable/sync cycle waits for the next event.
  always_comb begin
    w_hold  = '0;
    w_wrap  = '0;
    w_wr    = '0;
    w_apply = '0;
    for (int c = 0; c < NumChan; c++) begin
      w_hold[c]  = sync_i | ~en_i[c];
      w_wrap[c]  = (r_cnt[c] == r_half[c]);
      w_wr[c]    = cfg_valid_i & w_chan_ok & ~r_pend[c] & (cfg_chan_i == ChanW'(c));
      w_apply[c] = r_pend[c] & (w_hold[c] | w_wrap[c]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChan; c++) begin
        r_cnt[c]    <= '0;
        r_half[c]   <= HalfRst;
        r_shadow[c] <= HalfRst;
      end
      r_pend    <= '0;
      r_clk     <= '0;
      r_tick    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      // Out-of-range channels always show ready, so valid alone means accepted.
      r_cfg_err <= cfg_valid_i & ~w_chan_ok;
      for (int c = 0; c < NumChan; c++) begin
        if (w_hold[c]) begin
          r_cnt[c]  <= '0;
          r_clk[c]  <= 1'b0;
          r_tick[c] <= 1'b0;
        end else if (w_wrap[c]) begin
          r_cnt[c]  <= '0;
          r_clk[c]  <= ~r_clk[c];
          r_tick[c] <= ~r_clk[c];
        end else begin
          r_cnt[c]  <= r_cnt[c] + CntWidth'(1);
          r_tick[c] <= 1'b0;
        end

        // H only moves on a phase boundary, so no half-period is ever cut short.
        if (w_wr[c]) begin
          r_shadow[c] <= cfg_half_i;
          r_pend[c]   <= 1'b1;
        end else if (w_apply[c]) begin
          r_half[c]   <= r_shadow[c];
          r_pend[c]   <= 1'b0;
        end
      end
    end
  end

  assign clk_o     = r_clk;
  assign tick_o    = r_tick;
  assign cfg_err_o = r_cfg_err;

endmodule

// File: tb/tb_rtc_div_multi.sv
// Purpose : directed bench for rtc_div_multi with three channels and default half-period.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpres: configuration writes respect cfg_ready_o as exercised in each step.
module tb_rtc_div_multi;

  // Three channels so the 2-bit channel field can carry index 3, which is out of range.
  localparam int NumChan = 3;

  logic         clk_i;
  logic         rst_ni;
  logic [2:0]   en_i;
  logic         sync_i;
  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic [1:0]   cfg_chan_i;
  logic [15:0]  cfg_half_i;
  logic         cfg_err_o;
  logic [2:0]   clk_o;
  logic [2:0]   tick_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  rtc_div_multi #(
    .NumChan   (NumChan),
    .CntWidth  (16),
    .ResetHalf (24)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .sync_i      (sync_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_chan_i  (cfg_chan_i),
    .cfg_half_i  (cfg_half_i),
    .cfg_err_o   (cfg_err_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles until the next tick on channel c; 200 means it never came.
  task automatic wait_rise(input int c, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick_o[c] !== 1'b1 && n < 200);
  endtask

  // Cycles until clk_o[c] goes low; 200 means it never did.
  task automatic wait_fall(input int c, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clk_o[c] !== 1'b0 && n < 200);
  endtask

  initial begin
    int  n;
    int  n0;
    int  n1;
    int  ticks [3];
    int  highs [3];
    bit  bad;

    rst_ni      = 1'b0;
    en_i        = 3'b000;
    sync_i      = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_chan_i  = 2'd0;
    cfg_half_i  = 16'd0;
    step();
    step();

    // Reset state
    check("reset clk_o", {29'd0, clk_o}, 32'd0);
    check("reset tick_o", {29'd0, tick_o}, 32'd0);
    check("reset cfg_err_o", {31'd0, cfg_err_o}, 32'd0);
    check("reset cfg_ready_o", {31'd0, cfg_ready_o}, 32'd1);

    // Release with all channels enabled: first rise 25 cycles later, all in phase
    rst_ni = 1'b1;
    en_i   = 3'b111;
    wait_rise(0, n);
    check("first rise after release", n, 32'd25);
    check("all channels rise together", {29'd0, clk_o}, 32'd7);

    // 200 cycles: 4 periods of 50, 25 high each, one tick per period
    for (int c = 0; c < 3; c++) begin
      ticks[c] = 0;
      highs[c] = 0;
    end
    for (int i = 0; i < 200; i++) begin
      step();
      for (int c = 0; c < 3; c++) begin
        if (tick_o[c]) ticks[c]++;
        if (clk_o[c])  highs[c]++;
      end
    end
    for (int c = 0; c < 3; c++) begin
      check($sformatf("ch%0d ticks in 200", c), ticks[c], 32'd4);
      check($sformatf("ch%0d high cycles in 200", c), highs[c], 32'd100);
    end

    // Channel 0: write H=3 when its counter reads 10 (10 cycles after a rise)
    for (int i = 0; i < 10; i++) step();
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd0;
    cfg_half_i  = 16'd3;
    check("ch0 ready before write", {31'd0, cfg_ready_o}, 32'd1);
    step();
    cfg_valid_i = 1'b0;
    check("ch0 ready low after write", {31'd0, cfg_ready_o}, 32'd0);
    bad = 1'b0;
    n   = 0;
    do begin
      step();
      n++;
      if (clk_o[0] && cfg_ready_o !== 1'b0) bad = 1'b1;
    end while (clk_o[0] === 1'b1 && n < 200);
    check("ch0 old half-period runs out", n, 32'd14);
    check("ch0 ready stays low while pending", {31'd0, bad}, 32'd0);
    check("ch0 ready after apply", {31'd0, cfg_ready_o}, 32'd1);
    wait_rise(0, n);
    check("ch0 low time with H=3", n, 32'd4);
    wait_fall(0, n);
    check("ch0 high time with H=3", n, 32'd4);
    wait_rise(0, n);
    check("ch0 second low time with H=3", n, 32'd4);

    // Channel 1: counter is 12 now, wrap (rise) on the 13th edge; write H=0 in that cycle
    for (int i = 0; i < 12; i++) step();
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd1;
    cfg_half_i  = 16'd0;
    check("ch1 ready before wrap write", {31'd0, cfg_ready_o}, 32'd1);
    step();
    cfg_valid_i = 1'b0;
    check("ch1 wrap in accept cycle", {31'd0, tick_o[1]}, 32'd1);
    wait_fall(1, n);
    check("ch1 keeps H=24 through accept wrap", n, 32'd25);
    step();
    check("ch1 toggles right after apply", {30'd0, tick_o[1], clk_o[1]}, 32'd3);
    ticks[1] = 0;
    highs[1] = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick_o[1]) ticks[1]++;
      if (clk_o[1])  highs[1]++;
    end
    check("ch1 ticks in 8 cycles at H=0", ticks[1], 32'd4);
    check("ch1 high cycles in 8 at H=0", highs[1], 32'd4);

    // H=4 on ch0, H=9 on ch1, then sync applies both and restarts phase
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd0;
    cfg_half_i  = 16'd4;
    step();
    cfg_chan_i  = 2'd1;
    cfg_half_i  = 16'd9;
    step();
    cfg_valid_i = 1'b0;
    sync_i      = 1'b1;
    step();
    sync_i      = 1'b0;
    check("sync clears clk_o", {29'd0, clk_o}, 32'd0);
    check("sync clears tick_o", {29'd0, tick_o}, 32'd0);
    wait_rise(0, n0);
    check("ch0 first rise after sync", n0, 32'd5);
    check("ch1 still low at ch0 rise", {31'd0, clk_o[1]}, 32'd0);
    wait_rise(1, n1);
    check("ch1 first rise after sync", n0 + n1, 32'd10);

    // Out-of-range write: accepted, error pulse, no state change
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd3;
    cfg_half_i  = 16'd7;
    check("ready for out-of-range index", {31'd0, cfg_ready_o}, 32'd1);
    step();
    cfg_valid_i = 1'b0;
    check("cfg_err_o pulse", {31'd0, cfg_err_o}, 32'd1);
    step();
    check("cfg_err_o single cycle", {31'd0, cfg_err_o}, 32'd0);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    wait_rise(0, n0);
    check("ch0 H unchanged by bad write", n0, 32'd5);
    wait_rise(1, n1);
    check("ch1 H unchanged by bad write", n0 + n1, 32'd10);

    // Disable ch0 for one cycle while writing H=1: applies at the next wrap, not now
    en_i        = 3'b110;
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd0;
    cfg_half_i  = 16'd1;
    step();
    en_i        = 3'b111;
    cfg_valid_i = 1'b0;
    check("disabled ch0 clk_o/tick_o", {30'd0, tick_o[0], clk_o[0]}, 32'd0);
    wait_rise(0, n);
    check("ch0 rise after re-enable uses old H", n, 32'd5);
    wait_rise(0, n);
    check("ch0 period with H=1", n, 32'd4);

    // Reset mid-period with a write pending: value discarded
    cfg_valid_i = 1'b1;
    cfg_chan_i  = 2'd0;
    cfg_half_i  = 16'd2;
    step();
    cfg_valid_i = 1'b0;
    check("ch0 high before reset", {31'd0, clk_o[0]}, 32'd1);
    check("ch0 pending before reset", {31'd0, cfg_ready_o}, 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async reset clears clk_o", {29'd0, clk_o}, 32'd0);
    check("async reset clears pending", {31'd0, cfg_ready_o}, 32'd1);
    step();
    step();
    rst_ni = 1'b1;
    wait_rise(0, n);
    check("first rise after second release", n, 32'd25);
    wait_rise(0, n);
    check("period after reset discards pending", n, 32'd50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
